// File: rtl/seg7_hex_mux.sv
// ---------------------------------------------------------------------------
// seg7_hex_mux
//
// Two-digit time-multiplexed seven-segment driver. It sits downstream of the
// free-running seconds counter and shows that counter's 8-bit output as two
// hex digits. Each digit is preceded by an all-off gap so the segment lines
// have time to settle before the next digit is enabled, which avoids ghosting.
//
// A load strobe captures the byte into a shadow register at any time. The
// shadow moves into the display register only on the GAP0 -> DIG0 edge, so
// the two digits of one frame always come from the same byte.
//
// Frame sequence (ena held high):
//   GAP0 (GAP_CYCLES) -> DIG0 (REFRESH_DIV) -> GAP1 (GAP_CYCLES)
//        -> DIG1 (REFRESH_DIV) -> GAP0 ...
//
// Parameters:
//   REFRESH_DIV  - cycles each digit is lit (>= 2)
//   GAP_CYCLES   - all-off cycles before each digit (>= 1)
//   COMMON_ANODE - 1 inverts seg, dp and dig (active-low drive)
//
// Ports:
//   clk      in   clock
//   reset    in   synchronous, active-high reset
//   ena      in   advance enable; low freezes the phase counter and state
//   load     in   capture value into the shadow register at this edge
//   value    in   [3:0] low digit, [7:4] high digit
//   lz_blank in   blank the high digit when it is zero (sampled live)
//   seg      out  segments a..g on seg[0]..seg[6]
//   dp       out  decimal point; frame-parity heartbeat on the low digit
//   dig      out  one-hot digit enable, dig[0] = low digit
//   frame    out  pulse in the first cycle of DIG0
// ---------------------------------------------------------------------------
module seg7_hex_mux #(
   parameter int REFRESH_DIV  = 1024,
   parameter int GAP_CYCLES   = 16,
   parameter bit COMMON_ANODE = 1'b0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ena,
   input  logic       load,
   input  logic [7:0] value,
   input  logic       lz_blank,
   output logic [6:0] seg,
   output logic       dp,
   output logic [1:0] dig,
   output logic       frame
);

   // The phase counter has to reach the longer of the two phase lengths.
   localparam int MAX_CNT = (REFRESH_DIV > GAP_CYCLES) ? REFRESH_DIV : GAP_CYCLES;
   localparam int CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

   localparam logic [CNT_W-1:0] DIG_LAST = CNT_W'(REFRESH_DIV - 1);
   localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);

   // XOR masks that turn active-high values into the physical drive levels.
   localparam logic [6:0] SEG_POL = {7{COMMON_ANODE}};
   localparam logic [1:0] DIG_POL = {2{COMMON_ANODE}};
   localparam logic       DP_POL  = COMMON_ANODE;

   typedef enum logic [1:0] {
      GAP0 = 2'd0,
      DIG0 = 2'd1,
      GAP1 = 2'd2,
      DIG1 = 2'd3
   } state_t;

   state_t           state_q;
   state_t           state_next;
   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_next;
   logic [7:0]       shadow_q;
   logic [7:0]       display_q;
   logic [7:0]       display_next;
   logic             parity_q;
   logic             parity_next;

   logic [6:0]       seg_d;
   logic             dp_d;
   logic [1:0]       dig_d;
   logic             frame_d;

   // Hex digit to segment pattern, gfedcba ordering.
   function automatic logic [6:0] hex7(input logic [3:0] nibble);
      logic [6:0] pattern;
      case (nibble)
         4'h0:    pattern = 7'h3F;
         4'h1:    pattern = 7'h06;
         4'h2:    pattern = 7'h5B;
         4'h3:    pattern = 7'h4F;
         4'h4:    pattern = 7'h66;
         4'h5:    pattern = 7'h6D;
         4'h6:    pattern = 7'h7D;
         4'h7:    pattern = 7'h07;
         4'h8:    pattern = 7'h7F;
         4'h9:    pattern = 7'h6F;
         4'hA:    pattern = 7'h77;
         4'hB:    pattern = 7'h7C;
         4'hC:    pattern = 7'h39;
         4'hD:    pattern = 7'h5E;
         4'hE:    pattern = 7'h79;
         default: pattern = 7'h71;
      endcase
      return pattern;
   endfunction

   // Shadow register: captures the incoming byte on any load strobe, in any
   // state and regardless of ena, so a value written while the display is
   // frozen is not lost.
   always_ff @(posedge clk) begin
      if (reset) begin
         shadow_q <= 8'h00;
      end else if (load) begin
         shadow_q <= value;
      end
   end

   // Frame sequencer registers: state, phase counter, the byte being shown
   // and the heartbeat parity. All of them hold while ena is low.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= GAP0;
         count_q   <= '0;
         display_q <= 8'h00;
         parity_q  <= 1'b0;
      end else begin
         state_q   <= state_next;
         count_q   <= count_next;
         display_q <= display_next;
         parity_q  <= parity_next;
      end
   end

   // Next-state logic. The counter is compared with == against the length
   // of the current phase and cleared as the state advances. On GAP0 -> DIG0
   // the display takes the shadow as it stood before this edge, so a load
   // sampled on the same edge waits for the following frame.
   always_comb begin
      state_next   = state_q;
      count_next   = count_q;
      display_next = display_q;
      parity_next  = parity_q;
      if (ena) begin
         case (state_q)
            GAP0: begin
               if (count_q == GAP_LAST) begin
                  state_next   = DIG0;
                  count_next   = '0;
                  display_next = shadow_q;
                  parity_next  = ~parity_q;
               end else begin
                  count_next = count_q + 1'b1;
               end
            end
            DIG0: begin
               if (count_q == DIG_LAST) begin
                  state_next = GAP1;
                  count_next = '0;
               end else begin
                  count_next = count_q + 1'b1;
               end
            end
            GAP1: begin
               if (count_q == GAP_LAST) begin
                  state_next = DIG1;
                  count_next = '0;
               end else begin
                  count_next = count_q + 1'b1;
               end
            end
            default: begin
               if (count_q == DIG_LAST) begin
                  state_next = GAP0;
                  count_next = '0;
               end else begin
                  count_next = count_q + 1'b1;
               end
            end
         endcase
      end
   end

   // Output decode works on the next-state values so that the registered
   // outputs already match a state in the first cycle it is held. frame
   // follows count==0 in DIG0, which keeps it high while ena freezes that
   // first cycle.
   always_comb begin
      seg_d   = 7'h00;
      dp_d    = 1'b0;
      dig_d   = 2'b00;
      frame_d = 1'b0;
      case (state_next)
         DIG0: begin
            dig_d   = 2'b01;
            seg_d   = hex7(display_next[3:0]);
            dp_d    = parity_next;
            frame_d = (count_next == '0);
         end
         DIG1: begin
            if (!(lz_blank && (display_next[7:4] == 4'h0))) begin
               dig_d = 2'b10;
               seg_d = hex7(display_next[7:4]);
            end
         end
         default: begin
         end
      endcase
   end

   // Output registers. Reset forces everything off in the active-high sense;
   // the polarity masks are applied here so nothing combinational reaches
   // the pins.
   always_ff @(posedge clk) begin
      if (reset) begin
         seg   <= SEG_POL;
         dp    <= DP_POL;
         dig   <= DIG_POL;
         frame <= 1'b0;
      end else begin
         seg   <= seg_d ^ SEG_POL;
         dp    <= dp_d ^ DP_POL;
         dig   <= dig_d ^ DIG_POL;
         frame <= frame_d;
      end
   end

endmodule

// File: doc/seg7_hex_mux.md
# seg7_hex_mux

- Two-digit multiplexed seven-segment driver.
- Sits directly downstream of the free-running seconds counter and consumes its 8-bit output byte.
- Latches the byte on a load strobe and transfers it to the display only at frame boundaries, so a digit pair never tears.
- Time-multiplexes two hex digits, with dead-time gaps between them to suppress ghosting.

## Interface
Parameters:
- REFRESH_DIV, 1024: cycles each digit is lit; legal values ≥ 2.
- GAP_CYCLES, 16: all-off cycles before each digit; legal values ≥ 1.
- COMMON_ANODE, 0: when 1, invert `seg`, `dp` and `dig` (active-low).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- ena  in  1  advance enable; low freezes phase counter and state.
- load  in  1  capture `value` into the shadow register at this edge.
- value  in  8  byte to display; [3:0] is the low digit, [7:4] the high digit.
- lz_blank  in  1  suppress the high digit when it is 0 (sampled live).
- seg  out  7  segments; seg[0]=a … seg[6]=g.
- dp  out  1  decimal point, used as a frame heartbeat.
- dig  out  2  one-hot digit enable; dig[0] = low digit.
- frame  out  1  one-cycle pulse in the first cycle of DIG0.

## Operation
- The clock is `clk`. Reset is synchronous and active-high, named `reset`.
- State machine: GAP0 → DIG0 → GAP1 → DIG1 → GAP0.
- Phase counter:
  - In DIG states it counts 0..REFRESH_DIV-1; in GAP states 0..GAP_CYCLES-1.
  - At terminal count the state advances and the counter clears.
  - Both count and advance only when ena=1.
- Shadow register:
  - Takes `value` on any edge where load=1, in any state.
  - Loads while ena=0 are still captured.
- Display register:
  - On the edge GAP0→DIG0 it takes the shadow contents as they were before that edge.
  - A load in the final GAP0 cycle therefore lands in the shadow, and the display shows it one frame later.
- Heartbeat: the parity bit toggles on every GAP0→DIG0 edge.
- Outputs, stated in active-high sense and inverted when COMMON_ANODE=1:
  - GAP0/GAP1: seg=0, dp=0, dig=00.
  - DIG0: dig=01, seg=hex(display[3:0]), dp=parity.
  - DIG1: dig=10, seg=hex(display[7:4]), dp=0.
  - DIG1 when lz_blank=1 and display[7:4]=0: dig=00, seg=0.
- Hex decode, seg[6:0] (gfedcba): 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71.
- Register state at reset (takes priority over load and ena):
  - state=GAP0, counter=0, shadow=0, display=0, parity=0.
  - Outputs go off: seg=0, dp=0, dig=00, frame=0 (active-high sense).
- Reset mid-frame aborts the frame immediately; no load survives.
- Counter width is $clog2 of max(REFRESH_DIV, GAP_CYCLES).
- The counter never wraps past terminal count; it is compared with ==.

## Timing
- All outputs are registered and reflect the state they were decoded for from the first cycle that state is held. No combinational path runs from inputs to outputs.
- With ena held high, one frame = 2·(REFRESH_DIV+GAP_CYCLES) cycles.
- After reset deasserts:
  - GAP0 occupies cycles 0..GAP_CYCLES-1.
  - DIG0 and frame=1 start at cycle GAP_CYCLES.
- Load-to-display latency: from the load edge to the next GAP0→DIG0 edge, bounded by one frame.
- ena=0 for N cycles stretches the current phase by exactly N cycles.
- `frame` stays asserted while ena=0 holds the first DIG0 cycle.
- lz_blank affects only DIG1 outputs, starting the cycle after it changes.

## Test plan
Benches use REFRESH_DIV=8, GAP_CYCLES=2 (frame = 20 cycles) unless stated otherwise.
1. Reset held 3 cycles with load=1, value=A5 → seg=00, dp=0, dig=00 throughout. Release → cycles 0-1 GAP0; cycle 2 shows frame=1, dig=01, seg=3F, dp=1; cycle 12 shows dig=10, seg=3F.
2. Load 3C during DIG1 of frame 0 → frame 1 shows DIG0 seg=39 (C) and DIG1 seg=4F (3), with dp=0 in frame 1.
3. Load 11 in frame 0, then load 22 in the last GAP0 cycle → frame 1 shows 11; frame 2 shows 22.
4. lz_blank=1 with value 07 → DIG1 is dig=00, seg=00 for 8 cycles. Value 17 → DIG1 is dig=10, seg=06.
5. ena=0 for 5 cycles mid-DIG0 → DIG0 lasts 13 cycles, the frame 25 cycles; a load during the freeze still appears next frame.
6. COMMON_ANODE=1 → at reset seg=7F, dp=1, dig=11. Value 08 → DIG0 gives dig=10, seg=00.
